lift_call_scheduler: RTL
========================

# lift_call_scheduler

Floor-call scheduler for the lift. It latches hall and car call buttons for every floor and tracks the car position from floor-sensor pulses. It issues move-up, move-down and door-open commands using SCAN ordering: it keeps the current direction while calls remain ahead, then reverses. It sits above the lift motor/door controller, arbitrating between all pending floor requests, and drives that controller's up/down/door inputs.

## Interface
Parameters:
- FLOORS, 8, number of served floors (2..16)
- FLOOR_W, 3, width of floor index, ≥ clog2(FLOORS)
- DOOR_CYCLES, 16, cycles the door stays open per stop (≥2)
- WDOG_CYCLES, 1024, max cycles between floor_tick pulses while moving (watchdog only)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- call_req  in  FLOORS  one bit per floor, OR of hall and car buttons; level or pulse
- floor_tick  in  1  one-cycle pulse, car has reached the next floor in the commanded direction
- emergency  in  1  level; suspend all motion
- maintenance  in  1  level; suspend motion and discard calls
- move_up  out  1  command car upward
- move_down  out  1  command car downward
- door_open  out  1  command doors open
- cur_floor  out  FLOOR_W  current car floor
- calls_pending  out  FLOORS  latched, unserved calls
- dir_up  out  1  SCAN direction, 1 = up
- fault  out  1  sticky watchdog fault

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOORS, HALT.
- Call latch:
  - calls_pending[i] sets on call_req[i].
  - It clears when the car stops at floor i and enters DOORS.
  - call_req for cur_floor while in DOORS restarts the door timer and is not latched.
  - Call requests with index ≥ FLOORS do not exist; the width fixes this.
- IDLE decides in one cycle:
  - If there is a call at cur_floor: go to DOORS.
  - Else if dir_up=1 and a call exists above: go to MOVE_UP.
  - Else if a call exists below: go to MOVE_DOWN and set dir_up=0.
  - Else if a call exists above: go to MOVE_UP and set dir_up=1.
  - Else stay in IDLE.
- MOVE_UP:
  - On floor_tick, cur_floor increments.
  - If the new floor has a pending call, or the new floor is FLOORS-1: go to DOORS if a call exists there, else to IDLE.
  - floor_tick while cur_floor==FLOORS-1 is ignored (saturate).
- MOVE_DOWN mirrors MOVE_UP: cur_floor decrements and saturates at 0.
- DOORS:
  - Door counter loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to IDLE.
- floor_tick outside MOVE_UP/MOVE_DOWN is ignored.
- Priority per cycle: reset_n low > maintenance > emergency > watchdog fault > normal FSM.
- emergency: go to HALT and retain calls. When emergency drops and maintenance and fault are low, go to IDLE.
- maintenance: go to HALT, clear calls_pending, and ignore call_req while high. Exit as for emergency.
- Outputs are registered and decoded from the state:
  - move_up=1 only in MOVE_UP.
  - move_down=1 only in MOVE_DOWN.
  - door_open=1 only in DOORS.
  - All three are 0 in HALT.

## Timing
- Reset values:
  - state IDLE
  - cur_floor 0
  - dir_up 1
  - calls_pending 0
  - move_up, move_down, door_open, fault all 0
- call_req at edge N shows in calls_pending at N+1.
- From IDLE with one call, the move command asserts 1 cycle after the call latches.
- Stop: the floor_tick edge updates cur_floor, clears the call, and drops the move command. door_open asserts on the same edge.
- The door stays open for exactly DOOR_CYCLES cycles. IDLE follows, and the next move starts 1 cycle later.
- A call and a stop on the same floor in the same cycle: the call is cleared (served).
- Reset mid-motion forces reset values on the next edge. Calls are lost.

## Configuration
- LIFT_SCHED_WATCHDOG_EN defined:
  - A counter runs in MOVE_UP/MOVE_DOWN and reloads on each floor_tick.
  - When it reaches WDOG_CYCLES without a tick, the block sets fault and enters HALT.
  - fault is sticky until reset_n.
- LIFT_SCHED_WATCHDOG_EN undefined:
  - No counter.
  - fault is tied to 0.

## Structure
- Shared package lift_pkg holds:
  - the state enum (IDLE, MOVE_UP, MOVE_DOWN, DOORS, HALT), common with the other lift blocks
  - the direction constants DIR_UP/DIR_DOWN
- Sub-module lift_call_search: combinational. It takes calls_pending and cur_floor and returns any_above, any_below and at_floor. Mask-and-reduce, no priority encoder needed.
- The FSM, call latch, door counter and watchdog live in the top module.

## Test plan
- Reset, then call_req=8'b0000_0100 for one cycle:
  - move_up 2 cycles later.
  - After two floor_ticks, cur_floor=2, door_open for 16 cycles, calls_pending=0.
- Car at floor 5, dir_up=1, calls on floors 7 and 2:
  - Serves 7 first, then reverses and serves 2.
  - dir_up goes 0 on departure from 7.
- Moving up from floor 1, emergency raised mid-travel:
  - All commands 0 next cycle; calls retained.
  - On release, returns to IDLE and resumes toward the same call.
- maintenance high with calls pending:
  - calls_pending=0 next cycle; call_req ignored while high; FSM stays in HALT.
- call_req for cur_floor while door_open: door timer restarts, and the door stays open 16 more cycles.
- With LIFT_SCHED_WATCHDOG_EN defined and WDOG_CYCLES=1024, MOVE_UP with no floor_tick for 1024 cycles:
  - fault=1, move_up=0.
  - Fault persists after emergency/maintenance toggles until reset_n.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared lift package: controller state encoding and SCAN direction constants,
// common to all lift blocks.
package lift_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOORS,
        HALT
    } lift_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/lift_call_search.sv
// Combinational call search: reports whether any latched call lies above, below
// or at the given floor, using position masks and OR-reduction.
module lift_call_search #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
) (
    input  logic [FLOORS-1:0]  calls,
    input  logic [FLOOR_W-1:0] floor,
    output logic               any_above,
    output logic               any_below,
    output logic               at_floor
);

    logic [FLOORS-1:0] above_mask;
    logic [FLOORS-1:0] below_mask;
    logic [FLOORS-1:0] here_mask;

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        here_mask  = '0;
        for (int i = 0; i < FLOORS; i++) begin
            above_mask[i] = (i > int'(floor));
            below_mask[i] = (i < int'(floor));
            here_mask[i]  = (i == int'(floor));
        end
    end

    assign any_above = |(calls & above_mask);
    assign any_below = |(calls & below_mask);
    assign at_floor  = |(calls & here_mask);

endmodule

// File: rtl/lift_call_scheduler.sv
// SCAN floor-call scheduler: call latch, car position, door timer and motion FSM.
// Optional watchdog on floor_tick spacing is enabled by LIFT_SCHED_WATCHDOG_EN.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int FLOORS      = 8,
    parameter int FLOOR_W     = 3,
    parameter int DOOR_CYCLES = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [FLOORS-1:0]  call_req,
    input  logic               floor_tick,
    input  logic               emergency,
    input  logic               maintenance,
    output logic               move_up,
    output logic               move_down,
    output logic               door_open,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOORS-1:0]  calls_pending,
    output logic               dir_up,
    output logic               fault
);

    localparam int                 DOOR_W    = $clog2(DOOR_CYCLES);
    localparam logic [DOOR_W-1:0]  DOOR_LOAD = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

    lift_state_t        state_q;
    lift_state_t        state_d;
    logic [FLOOR_W-1:0] floor_d;
    logic               dir_d;
    logic [DOOR_W-1:0]  door_cnt;
    logic [DOOR_W-1:0]  door_d;
    logic [FLOORS-1:0]  calls_d;
    logic [FLOORS-1:0]  served;
    logic [FLOORS-1:0]  ignored;
    logic [FLOORS-1:0]  here_mask;
    logic [FLOORS-1:0]  up_mask;
    logic [FLOORS-1:0]  down_mask;
    logic               any_above;
    logic               any_below;
    logic               at_floor;
    logic               moving;
    logic               halt_req;
    logic               wdog_trip;

    lift_call_search #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_search (
        .calls     (calls_pending),
        .floor     (cur_floor),
        .any_above (any_above),
        .any_below (any_below),
        .at_floor  (at_floor)
    );

    // One-hot masks for the current floor and its two neighbours.
    always_comb begin
        here_mask = '0;
        up_mask   = '0;
        down_mask = '0;
        for (int i = 0; i < FLOORS; i++) begin
            here_mask[i] = (i == int'(cur_floor));
            up_mask[i]   = (i == int'(cur_floor) + 1);
            down_mask[i] = (i == int'(cur_floor) - 1);
        end
    end

    assign moving   = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
    assign halt_req = maintenance || emergency || fault || wdog_trip;

`ifdef LIFT_SCHED_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_trip = moving && !floor_tick && !maintenance && !emergency &&
                       (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            if (!moving || floor_tick) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
            if (wdog_trip) begin
                fault <= 1'b1;
            end
        end
    end
`else
    // No watchdog: only a degenerate zero-cycle limit could ever trip.
    assign wdog_trip = (WDOG_CYCLES < 1);
    assign fault     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        floor_d = cur_floor;
        dir_d   = dir_up;
        door_d  = door_cnt;
        served  = '0;
        ignored = '0;
        if (halt_req) begin
            state_d = HALT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (at_floor) begin
                        state_d = DOORS;
                        door_d  = DOOR_LOAD;
                        served  = here_mask;
                    end else if (dir_up && any_above) begin
                        state_d = MOVE_UP;
                    end else if (any_below) begin
                        state_d = MOVE_DOWN;
                        dir_d   = DIR_DOWN;
                    end else if (any_above) begin
                        state_d = MOVE_UP;
                        dir_d   = DIR_UP;
                    end
                end
                MOVE_UP: begin
                    if (floor_tick && (cur_floor != TOP_FLOOR)) begin
                        floor_d = cur_floor + FLOOR_W'(1);
                        if (|(calls_pending & up_mask)) begin
                            state_d = DOORS;
                            door_d  = DOOR_LOAD;
                            served  = up_mask;
                        end else if (floor_d == TOP_FLOOR) begin
                            state_d = IDLE;
                        end
                    end
                end
                MOVE_DOWN: begin
                    if (floor_tick && (cur_floor != '0)) begin
                        floor_d = cur_floor - FLOOR_W'(1);
                        if (|(calls_pending & down_mask)) begin
                            state_d = DOORS;
                            door_d  = DOOR_LOAD;
                            served  = down_mask;
                        end else if (floor_d == '0) begin
                            state_d = IDLE;
                        end
                    end
                end
                DOORS: begin
                    // A press at the open floor holds the door instead of queueing a call.
                    ignored = here_mask;
                    if (|(call_req & here_mask)) begin
                        door_d = DOOR_LOAD;
                    end else if (door_cnt == '0) begin
                        state_d = IDLE;
                    end else begin
                        door_d = door_cnt - DOOR_W'(1);
                    end
                end
                HALT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (maintenance) begin
            calls_d = '0;
        end else begin
            calls_d = (calls_pending | (call_req & ~ignored)) & ~served;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cur_floor     <= '0;
            dir_up        <= DIR_UP;
            calls_pending <= '0;
            door_cnt      <= '0;
        end else begin
            state_q       <= state_d;
            cur_floor     <= floor_d;
            dir_up        <= dir_d;
            calls_pending <= calls_d;
            door_cnt      <= door_d;
        end
    end

    assign move_up   = (state_q == MOVE_UP);
    assign move_down = (state_q == MOVE_DOWN);
    assign door_open = (state_q == DOORS);

endmodule
